// File: rtl/block_serializer.sv
// Parallel-to-serial converter: captures a WORD_W*WORDS block in one cycle and emits it
// LS word first with first/last markers; one word per ready cycle, all outputs registered.
module block_serializer #(
  parameter int WORD_W = 64,
  parameter int WORDS  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      load_i,
  input  logic [WORD_W*WORDS-1:0]   block_i,
  input  logic                      ready_i,
  output logic                      busy_o,
  output logic [WORD_W-1:0]         word_o,
  output logic                      valid_o,
  output logic                      first_o,
  output logic                      last_o
);

  localparam int BLK_W = WORD_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  logic [BLK_W-1:0] sr_q, sr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;

  logic xfer, at_last, accept;

  always_comb begin
    xfer    = valid_q & ready_i;
    at_last = valid_q & (idx_q == LAST_IDX);
    // A new block may replace the final word in the same cycle it hands off.
    accept  = load_i & (~valid_q | (at_last & xfer));

    sr_d    = sr_q;
    idx_d   = idx_q;
    valid_d = valid_q;

    if (accept) begin
      sr_d    = block_i;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (xfer) begin
      if (at_last) begin
        sr_d    = '0;
        idx_d   = '0;
        valid_d = 1'b0;
      end else begin
        sr_d    = sr_q >> WORD_W;
        idx_d   = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  // Outputs are decoded only from flops, so there is no input-to-output path.
  assign word_o  = sr_q[WORD_W-1:0];
  assign valid_o = valid_q;
  assign busy_o  = valid_q;
  assign first_o = valid_q & (idx_q == '0);
  assign last_o  = valid_q & (idx_q == LAST_IDX);

endmodule

// File: tb/tb_block_serializer.sv
// Directed stimulus with a queue-based scoreboard; a negedge monitor checks every transferred word.
module tb_block_serializer;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          load_i;
  logic [1023:0] block_i;
  logic          ready_i;
  logic          busy_o;
  logic [63:0]   word_o;
  logic          valid_o;
  logic          first_o;
  logic          last_o;

  int errors = 0;
  int checks = 0;
  logic [65:0] exp_q[$];   // {last, first, word}

  block_serializer #(.WORD_W(64), .WORDS(16)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load_i),
    .block_i (block_i),
    .ready_i (ready_i),
    .busy_o  (busy_o),
    .word_o  (word_o),
    .valid_o (valid_o),
    .first_o (first_o),
    .last_o  (last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1023:0] mk_blk(input logic [63:0] base, input logic [63:0] step);
    logic [1023:0] b;
    b = '0;
    for (int k = 0; k < 16; k++) b[64*k +: 64] = base + step * 64'(k);
    return b;
  endfunction

  task automatic push_words(input logic [63:0] base, input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back({(k == 15), (k == 0), base + 64'(k)});
  endtask

  // Monitor: every handshake must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_i && valid_o && ready_i) begin
      logic [65:0] e;
      chk("busy_eq_valid", {63'd0, busy_o}, 64'd1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h expected none at %0t", word_o, $time);
      end else begin
        e = exp_q.pop_front();
        chk("word", word_o, e[63:0]);
        chk("first", {63'd0, first_o}, {63'd0, e[64]});
        chk("last", {63'd0, last_o}, {63'd0, e[65]});
      end
    end
  end

  task automatic chk_idle(input string name);
    chk({name, "_valid"}, {63'd0, valid_o}, 64'd0);
    chk({name, "_busy"},  {63'd0, busy_o},  64'd0);
    chk({name, "_first"}, {63'd0, first_o}, 64'd0);
    chk({name, "_last"},  {63'd0, last_o},  64'd0);
    chk({name, "_word"},  word_o, 64'd0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (valid_o && n < 60) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk({name, "_drain_timeout"}, {63'd0, valid_o}, 64'd0);
    chk({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Drives a one-cycle load; returns #1 after the accept edge (word 0 presented).
  task automatic send(input logic [1023:0] blk);
    block_i = blk;
    load_i  = 1'b1;
    @(posedge clk_i); #1;
    load_i  = 1'b0;
    block_i = '0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; load_i = 1'b0; ready_i = 1'b1; block_i = '0;
    #12;
    chk_idle("reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    step(1);
    chk_idle("post_reset");

    // Basic send with latency and end-of-block timing.
    push_words(64'h100, 16);
    send(mk_blk(64'h100, 64'd1));
    chk("basic_lat_valid", {63'd0, valid_o}, 64'd1);
    chk("basic_lat_word", word_o, 64'h100);
    step(15);
    chk("basic_last_word", word_o, 64'h10F);
    chk("basic_last_flag", {63'd0, last_o}, 64'd1);
    step(1);
    chk_idle("basic_end");
    wait_idle("basic");

    // Backpressure on word 5.
    push_words(64'h100, 16);
    send(mk_blk(64'h100, 64'd1));
    step(5);
    ready_i = 1'b0;
    chk("bp_hold0", word_o, 64'h105);
    for (int i = 1; i < 4; i++) begin
      step(1);
      chk("bp_hold_word", word_o, 64'h105);
      chk("bp_hold_valid", {63'd0, valid_o}, 64'd1);
    end
    ready_i = 1'b1;
    step(1);
    chk("bp_resume", word_o, 64'h106);
    wait_idle("bp");

    // Load while busy is ignored.
    push_words(64'h200, 16);
    send(mk_blk(64'h200, 64'd1));
    step(7);
    block_i = mk_blk(64'hDEAD_BEEF_DEAD_BEEF, 64'd0);
    load_i  = 1'b1;
    step(1);
    load_i  = 1'b0;
    block_i = '0;
    chk("busy_load_word8", word_o, 64'h208);
    wait_idle("busy_load");
    step(1);
    chk_idle("busy_load_end");

    // Back-to-back blocks: 32 contiguous words.
    push_words(64'h300, 16);
    send(mk_blk(64'h300, 64'd1));
    step(15);
    chk("b2b_a_last", {63'd0, last_o}, 64'd1);
    push_words(64'h400, 16);
    send(mk_blk(64'h400, 64'd1));
    chk("b2b_b_first", {63'd0, first_o}, 64'd1);
    chk("b2b_b_word0", word_o, 64'h400);
    for (int i = 1; i < 16; i++) begin
      step(1);
      chk("b2b_contig", {63'd0, valid_o}, 64'd1);
    end
    step(1);
    chk("b2b_end", {63'd0, valid_o}, 64'd0);
    wait_idle("b2b");

    // Asynchronous reset during word 9, then a clean block.
    push_words(64'h500, 9);
    send(mk_blk(64'h500, 64'd1));
    step(9);
    chk("rst_mid_word9", word_o, 64'h509);
    #2;
    rst_i = 1'b1;
    #1;
    chk_idle("rst_async");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk_idle("rst_release");
    chk("rst_sb_empty", 64'(exp_q.size()), 64'd0);
    step(2);
    chk_idle("rst_idle");
    push_words(64'h600, 16);
    send(mk_blk(64'h600, 64'd1));
    chk("c_word0", word_o, 64'h600);
    chk("c_first", {63'd0, first_o}, 64'd1);
    wait_idle("c");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
